// File: rtl/twowire_pkg.sv
// twowire_pkg: shared state encoding and constants for the Two-Wire Debug APB splitter
package twowire_pkg;
  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP} state_t;
  localparam int W_DATA = 32;
  localparam int TIMEOUT_CYCLES_DFLT = 255;
endpackage

// File: rtl/twowire_apb_splitter_decode.sv
// twowire_apb_splitter_decode: port index extraction, range/present check, one-hot select
module twowire_apb_splitter_decode #(
  parameter int W_ADDR = 16,
  parameter int N_PORTS = 4,
  parameter int W_SEL = 2
) (
  input  logic [W_ADDR-1:0]       i_paddr,
  input  logic [N_PORTS-1:0]      i_present,
  output logic [W_SEL-1:0]        o_idx,
  output logic [W_ADDR-W_SEL-1:0] o_off,
  output logic                    o_hit,
  output logic [N_PORTS-1:0]      o_hot
);
  logic [2**W_SEL-1:0] w_pres;
  genvar g;
  assign o_idx = i_paddr[W_ADDR-1 -: W_SEL];
  assign o_off = i_paddr[W_ADDR-W_SEL-1:0];
  // indices past N_PORTS read as absent, folding the range check into the present lookup
  for (g = 0; g < 2**W_SEL; g++) begin : g_pres
    if (g < N_PORTS) begin : g_in
      assign w_pres[g] = i_present[g];
    end else begin : g_out
      assign w_pres[g] = 1'b0;
    end
  end
  assign o_hit = w_pres[o_idx];
  for (g = 0; g < N_PORTS; g++) begin : g_hot
    assign o_hot[g] = o_hit && (o_idx == W_SEL'(g));
  end
endmodule

// File: rtl/twowire_apb_splitter.sv
// twowire_apb_splitter: registered APB3 1-to-N fan-out behind the Two-Wire Debug DTM.
// Define TWOWIRE_APB_SPLITTER_TIMEOUT_EN to abort targets that never assert pready.
module twowire_apb_splitter
  import twowire_pkg::*;
#(
  parameter int W_ADDR = 16,
  parameter int N_PORTS = 4,
  parameter int W_SEL = 2,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DFLT
) (
  input  logic                      dck,
  input  logic                      drst,
  input  logic [W_ADDR-1:0]         src_paddr,
  input  logic                      src_psel,
  input  logic                      src_penable,
  input  logic                      src_pwrite,
  input  logic [W_DATA-1:0]         src_pwdata,
  output logic                      src_pready,
  output logic                      src_pslverr,
  output logic [W_DATA-1:0]         src_prdata,
  input  logic [N_PORTS-1:0]        port_present,
  output logic [W_ADDR-W_SEL-1:0]   dst_paddr,
  output logic [N_PORTS-1:0]        dst_psel,
  output logic                      dst_penable,
  output logic                      dst_pwrite,
  output logic [W_DATA-1:0]         dst_pwdata,
  input  logic [N_PORTS-1:0]        dst_pready,
  input  logic [N_PORTS-1:0]        dst_pslverr,
  input  logic [W_DATA*N_PORTS-1:0] dst_prdata
);
  state_t                  r_state;
  logic [N_PORTS-1:0]      r_hot;
  logic [W_SEL-1:0]        w_idx;
  logic [W_ADDR-W_SEL-1:0] w_off;
  logic                    w_hit;
  logic [N_PORTS-1:0]      w_hot;
  logic                    w_rdy;
  logic                    w_err;
  logic                    w_tmo;
  logic [W_DATA-1:0]       w_rdata;
  twowire_apb_splitter_decode #(.W_ADDR(W_ADDR), .N_PORTS(N_PORTS), .W_SEL(W_SEL)) u_decode (
    .i_paddr(src_paddr), .i_present(port_present),
    .o_idx(w_idx), .o_off(w_off), .o_hit(w_hit), .o_hot(w_hot)
  );
  // r_hot keeps the selected port even after a timeout drops dst_psel
  always_comb begin
    w_rdy = |(dst_pready & r_hot);
    w_err = |(dst_pslverr & r_hot);
    w_rdata = '0;
    for (int i = 0; i < N_PORTS; i++) w_rdata = w_rdata | (r_hot[i] ? dst_prdata[W_DATA*i +: W_DATA] : '0);
  end
`ifdef TWOWIRE_APB_SPLITTER_TIMEOUT_EN
  logic [15:0] r_cnt;
  assign w_tmo = (r_cnt + 16'd1) == 16'(TIMEOUT_CYCLES);
  always_ff @(posedge dck) begin
    if (drst || r_state != S_ACCESS) r_cnt <= '0;
    else if (!w_rdy) r_cnt <= r_cnt + 16'd1;
  end
`else
  // TIMEOUT_CYCLES is 1..65535, so this is never set: S_ACCESS waits for pready
  assign w_tmo = TIMEOUT_CYCLES == 0;
`endif
  always_ff @(posedge dck) begin
    if (drst) begin
      r_state <= S_IDLE;
      r_hot <= '0;
      src_pready <= 1'b0;
      src_pslverr <= 1'b0;
      src_prdata <= '0;
      dst_paddr <= '0;
      dst_psel <= '0;
      dst_penable <= 1'b0;
      dst_pwrite <= 1'b0;
      dst_pwdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (src_psel && !src_penable) begin
          r_hot <= w_hot;
          dst_paddr <= w_off;
          dst_pwrite <= src_pwrite;
          dst_pwdata <= src_pwdata;
          r_state <= w_hit ? S_SETUP : S_RESP;
          dst_psel <= w_hot;
          src_pready <= !w_hit;
          src_pslverr <= !w_hit;
          if (!w_hit) src_prdata <= '0;
        end
        S_SETUP: begin
          r_state <= S_ACCESS;
          dst_penable <= 1'b1;
        end
        S_ACCESS: if (w_rdy || w_tmo) begin
          r_state <= S_RESP;
          dst_psel <= '0;
          dst_penable <= 1'b0;
          src_pready <= 1'b1;
          src_pslverr <= w_rdy ? w_err : 1'b1;
          src_prdata <= (w_rdy && !dst_pwrite) ? w_rdata : '0;
        end
        default: begin
          r_state <= S_IDLE;
          src_pready <= 1'b0;
          src_pslverr <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_twowire_apb_splitter.sv
// tb_twowire_apb_splitter: directed scoreboard bench for the APB splitter
module tb_twowire_apb_splitter;
  localparam int TMO = 8;
  typedef struct packed {logic [31:0] d; logic e; logic [15:0] lat;} exp_t;
  logic        dck = 0, drst = 1;
  logic [15:0] src_paddr = '0;
  logic        src_psel = 0, src_penable = 0, src_pwrite = 0, u3_psel = 0;
  logic [31:0] src_pwdata = '0, src_prdata;
  logic        src_pready, src_pslverr;
  logic [3:0]  port_present = 4'b1111;
  logic [13:0] dst_paddr;
  logic [3:0]  dst_psel, dst_pready, dst_pslverr, tgt_err = '0;
  logic        dst_penable, dst_pwrite;
  logic [31:0] dst_pwdata;
  logic [127:0] dst_prdata;
  logic [31:0] tgt_data [4];
  int          tgt_wait [4];
  int          wcnt [4];
  logic        u3_pready, u3_pslverr, u3_penable, u3_pwrite;
  logic [31:0] u3_prdata, u3_pwdata;
  logic [13:0] u3_paddr;
  logic [2:0]  u3_psel_o;
  exp_t        sb[$];
  int          nchk = 0, nfail = 0;

  always #5 dck = ~dck;

  twowire_apb_splitter #(.W_ADDR(16), .N_PORTS(4), .W_SEL(2), .TIMEOUT_CYCLES(TMO)) dut (
    .dck(dck), .drst(drst), .src_paddr(src_paddr), .src_psel(src_psel), .src_penable(src_penable),
    .src_pwrite(src_pwrite), .src_pwdata(src_pwdata), .src_pready(src_pready), .src_pslverr(src_pslverr),
    .src_prdata(src_prdata), .port_present(port_present), .dst_paddr(dst_paddr), .dst_psel(dst_psel),
    .dst_penable(dst_penable), .dst_pwrite(dst_pwrite), .dst_pwdata(dst_pwdata), .dst_pready(dst_pready),
    .dst_pslverr(dst_pslverr), .dst_prdata(dst_prdata)
  );

  twowire_apb_splitter #(.W_ADDR(16), .N_PORTS(3), .W_SEL(2), .TIMEOUT_CYCLES(TMO)) dut3 (
    .dck(dck), .drst(drst), .src_paddr(src_paddr), .src_psel(u3_psel), .src_penable(src_penable),
    .src_pwrite(src_pwrite), .src_pwdata(src_pwdata), .src_pready(u3_pready), .src_pslverr(u3_pslverr),
    .src_prdata(u3_prdata), .port_present(3'b111), .dst_paddr(u3_paddr), .dst_psel(u3_psel_o),
    .dst_penable(u3_penable), .dst_pwrite(u3_pwrite), .dst_pwdata(u3_pwdata), .dst_pready(3'b111),
    .dst_pslverr(3'b000), .dst_prdata({3{32'h5A5A5A5A}})
  );

  // target model: each port answers after tgt_wait access cycles
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      dst_pready[i] = dst_psel[i] && dst_penable && (wcnt[i] >= tgt_wait[i]);
      dst_pslverr[i] = tgt_err[i] && dst_pready[i];
      dst_prdata[32*i +: 32] = tgt_data[i];
    end
  end
  always_ff @(posedge dck)
    for (int i = 0; i < 4; i++) wcnt[i] <= (dst_psel[i] && dst_penable && !dst_pready[i]) ? wcnt[i] + 1 : 0;

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    nchk++;
    assert (o === e) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  task automatic xfer(input string tag, input logic [15:0] a, input logic w, input logic [31:0] wd,
                      input logic [3:0] exp_sel, input logic [31:0] exp_d, input logic exp_e, input int exp_lat);
    exp_t x;
    logic got = 0;
    int lat = 0;
    sb.push_back('{exp_d, exp_e, 16'(exp_lat)});
    @(posedge dck); #1;
    src_psel = 1; src_penable = 0; src_paddr = a; src_pwrite = w; src_pwdata = wd;
    @(posedge dck); #1;
    src_penable = 1;
    for (int k = 1; k <= 200; k++) begin
      @(negedge dck);
      if (k == 1) begin
        chk({tag, " psel@T1"}, 64'(dst_psel), 64'(exp_sel));
        chk({tag, " paddr"}, 64'(dst_paddr), 64'(a[13:0]));
        chk({tag, " pwrite"}, 64'(dst_pwrite), 64'(w));
        chk({tag, " pwdata"}, 64'(dst_pwdata), 64'(wd));
      end
      if (src_pready) begin
        got = 1; lat = k;
        break;
      end
    end
    chk({tag, " responded"}, 64'(got), 64'd1);
    x = sb.pop_front();
    if (got) begin
      chk({tag, " latency"}, 64'(lat), 64'(x.lat));
      chk({tag, " prdata"}, 64'(src_prdata), 64'(x.d));
      chk({tag, " pslverr"}, 64'(src_pslverr), 64'(x.e));
      chk({tag, " psel@resp"}, 64'(dst_psel), 64'd0);
    end
    @(posedge dck); #1;
    src_psel = 0; src_penable = 0;
  endtask

  initial begin
    int hang;
    tgt_data[0] = 32'h11110000; tgt_data[1] = 32'hCAFEF00D;
    tgt_data[2] = 32'h22222222; tgt_data[3] = 32'h33333333;
    for (int i = 0; i < 4; i++) tgt_wait[i] = 0;
    repeat (3) @(posedge dck);
    @(negedge dck);
    chk("rst pready", 64'(src_pready), 64'd0);
    chk("rst pslverr", 64'(src_pslverr), 64'd0);
    chk("rst prdata", 64'(src_prdata), 64'd0);
    chk("rst dst", {dst_psel, dst_penable, dst_pwrite, dst_paddr, dst_pwdata}, 64'd0);
    drst = 0;
    xfer("rd p1", 16'h4123, 0, 32'h0, 4'b0010, 32'hCAFEF00D, 0, 3);
    tgt_wait[0] = 2;
    xfer("wr p0", 16'h0042, 1, 32'h12345678, 4'b0001, 32'h0, 0, 5);
    tgt_wait[0] = 0;
    port_present = 4'b1011;
    xfer("absent p2", 16'h8010, 0, 32'h0, 4'b0000, 32'h0, 1, 1);
    port_present = 4'b1111;
    @(posedge dck); #1;
    u3_psel = 1; src_penable = 0; src_paddr = 16'hC000; src_pwrite = 0;
    @(posedge dck); #1;
    src_penable = 1;
    @(negedge dck);
    chk("n3 idx3 pready", 64'(u3_pready), 64'd1);
    chk("n3 idx3 pslverr", 64'(u3_pslverr), 64'd1);
    chk("n3 idx3 psel", 64'(u3_psel_o), 64'd0);
    @(posedge dck); #1;
    u3_psel = 0; src_penable = 0;
    tgt_err[3] = 1;
    xfer("err p3", 16'hC004, 0, 32'h0, 4'b1000, 32'h33333333, 1, 3);
    tgt_err[3] = 0;
    xfer("b2b p0", 16'h0008, 0, 32'h0, 4'b0001, 32'h11110000, 0, 3);
    tgt_wait[2] = 60000;
`ifdef TWOWIRE_APB_SPLITTER_TIMEOUT_EN
    xfer("timeout p2", 16'h8100, 0, 32'h0, 4'b0100, 32'h0, 1, TMO + 2);
`else
    @(posedge dck); #1;
    src_psel = 1; src_penable = 0; src_paddr = 16'h8100; src_pwrite = 0;
    @(posedge dck); #1;
    src_penable = 1;
    hang = 0;
    repeat (1000) begin
      @(negedge dck);
      if (src_pready) hang++;
    end
    chk("hang pready", 64'(hang), 64'd0);
    chk("hang psel", 64'(dst_psel), 64'b0100);
    @(posedge dck); #1;
    drst = 1; src_psel = 0; src_penable = 0;
    @(posedge dck); #1;
    drst = 0;
`endif
    tgt_wait[2] = 0;
    tgt_wait[0] = 50;
    @(posedge dck); #1;
    src_psel = 1; src_penable = 0; src_paddr = 16'h0ABC; src_pwrite = 1; src_pwdata = 32'hDEADBEEF;
    @(posedge dck); #1;
    src_penable = 1;
    repeat (2) @(posedge dck);
    #1;
    chk("pre-rst penable", 64'(dst_penable), 64'd1);
    drst = 1;
    @(posedge dck); #1;
    drst = 0; src_psel = 0; src_penable = 0;
    @(negedge dck);
    chk("midrst pready", 64'(src_pready), 64'd0);
    chk("midrst prdata", 64'(src_prdata), 64'd0);
    chk("midrst dst", {dst_psel, dst_penable, dst_pwrite, dst_paddr, dst_pwdata}, 64'd0);
    tgt_wait[0] = 0;
    xfer("post-rst p1", 16'h4200, 0, 32'h0, 4'b0010, 32'hCAFEF00D, 0, 3);
    chk("sb empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule

// File: doc/twowire_apb_splitter.md
# twowire_apb_splitter

Registered APB3 fan-out stage directly downstream of the Two-Wire Debug DTM core's bus master port. Takes the DTM's single 32-bit APB3 master and routes each transfer to one of N_PORTS downstream APB targets, selected by the top address bits. Absent or out-of-range targets get an immediate error response. An optional timeout aborts hung targets so the debugger always gets a response.

## Interface
Parameters:
- W_ADDR, 16: upstream address width (DTM `8*(1+ASIZE)`).
- N_PORTS, 4: number of downstream targets, 1..16.
- W_SEL, 2: top address bits used as port index; 2^W_SEL >= N_PORTS, W_SEL < W_ADDR.
- TIMEOUT_CYCLES, 255: access-phase cycle limit (timeout builds only), 1..65535.

Ports:
- dck  in  1  debug clock; the only clock.
- drst  in  1  synchronous, active-high reset.
- src_paddr  in  W_ADDR  upstream address.
- src_psel, src_penable, src_pwrite  in  1  upstream APB3 controls.
- src_pwdata  in  32  upstream write data.
- src_pready  out  1  upstream ready.
- src_pslverr  out  1  upstream error, valid with src_pready.
- src_prdata  out  32  upstream read data, registered.
- port_present  in  N_PORTS  per-target present flag (same vector fed to DTM ainfo_present).
- dst_paddr  out  W_ADDR-W_SEL  offset within target: latched src_paddr[W_ADDR-W_SEL-1:0].
- dst_psel  out  N_PORTS  one-hot target select.
- dst_penable, dst_pwrite  out  1  shared.
- dst_pwdata  out  32  shared, latched.
- dst_pready, dst_pslverr  in  N_PORTS  per-target responses.
- dst_prdata  in  32*N_PORTS  per-target read data; port i at [32*i +: 32].

## Operation
- States: S_IDLE, S_SETUP, S_ACCESS, S_RESP.
- S_IDLE:
  - On src_psel && !src_penable, latch address, write data, pwrite and index = src_paddr[W_ADDR-1 -: W_SEL].
  - If index >= N_PORTS or !port_present[index]: set err, set rdata to 0, go to S_RESP.
  - Otherwise go to S_SETUP.
- S_SETUP: dst_psel[index]=1, dst_penable=0. Go to S_ACCESS.
- S_ACCESS: dst_psel[index]=1, dst_penable=1.
  - On dst_pready[index]: capture dst_pslverr[index] as err.
  - Capture dst_prdata slice as rdata on reads; on writes rdata is 0.
  - Go to S_RESP.
- S_RESP: src_pready=1, src_pslverr=err, src_prdata=rdata. Go to S_IDLE.
- src_pready and src_pslverr are 0 outside S_RESP. src_prdata holds its last captured value.
- Only dst_pready/pslverr/prdata of the selected port are observed; other ports' inputs are ignored.
- Upstream abandon: if src_psel is low in S_SETUP or S_ACCESS, the downstream transfer still completes. The S_RESP response is then ignored by the master; no corruption.
- Reset mid-transfer: next cycle is S_IDLE, all dst_psel low, no response issued.

## Timing
- Reset values: src_pready 0, src_pslverr 0, src_prdata 0, dst_psel 0, dst_penable 0, dst_pwrite 0, dst_paddr 0, dst_pwdata 0; state S_IDLE.
- Upstream setup at T0 with a zero-wait target:
  - T1: dst setup.
  - T2: dst access with pready.
  - T3: src_pready.
  - The upstream access phase is therefore 3 cycles plus target wait states.
- Decode error: src_pready at T1, i.e. in the first upstream access cycle.
- Back-to-back: a new upstream setup is accepted in the cycle after S_RESP.

## Configuration
- TWOWIRE_APB_SPLITTER_TIMEOUT_EN defined:
  - A 16-bit counter clears on S_ACCESS entry and increments each S_ACCESS cycle without dst_pready[index].
  - When it reaches TIMEOUT_CYCLES: drop dst_psel/dst_penable, set err=1 and rdata=0, go to S_RESP.
  - A pready arriving in the same cycle as the limit wins over the timeout.
- Undefined: no counter; S_ACCESS waits indefinitely for dst_pready.

## Structure
- Shared package twowire_pkg holds:
  - the state encoding (2-bit S_IDLE..S_RESP);
  - W_DATA = 32;
  - the default TIMEOUT_CYCLES constant.
- One sub-module, twowire_apb_splitter_decode: combinational index extraction, range/present check, one-hot select generation.
- State machine, latches and timeout counter live in the top module.

## Test plan
- Read port 1, zero-wait target, W_ADDR=16: src_paddr=0x4123.
  - dst_psel=0b0010 and dst_paddr=0x0123 at T1.
  - src_pready at T3 with src_prdata = port-1 data 0xCAFEF00D, pslverr 0.
- Write port 0 with 2 wait states, pwdata 0x12345678: dst_pwdata matches, src_pready at T5, src_prdata 0.
- port_present=0b1011, access port 2: no dst_psel ever; src_pready=1 and pslverr=1 at T1.
- With N_PORTS=3, access index 3: error at T1.
- Target returns pslverr on port 3: src_pslverr=1. Then an immediate second access to port 0 succeeds.
- Timeout build, TIMEOUT_CYCLES=8, target never ready: dst_psel drops after 8 access cycles, then src_pready with pslverr=1.
- Non-timeout build: still waiting after 1000 cycles.
- drst during S_ACCESS: all outputs at reset values the next cycle; a following access completes normally.
